// File: rtl/bin2sc_array.sv
// bin2sc_array: converts COL signed binary lanes into paired stochastic
// bitstreams (positive / negative). Each lane emits 2 bits per cycle for
// 2^W-1 cycles. Bit0 compares a shared LFSR against the lane magnitude.
// Bit1 compares the bit-reversed LFSR against the same magnitude.
module bin2sc_array #(
  parameter int BITWIDTH = 8,
  parameter int COL      = 32,
  parameter int SEED     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic [BITWIDTH*COL-1:0] bin_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [COL-1:0]          lane_mask,
  output logic [2*COL-1:0]        sc_pos,
  output logic [2*COL-1:0]        sc_neg,
  output logic                    cnt_en,
  output logic                    done
);

  localparam int W = BITWIDTH - 1;
  localparam logic [W-1:0] SEED_MOD = W'(SEED);
  localparam logic [W-1:0] SEED_EFF = (SEED_MOD == '0) ? W'(1) : SEED_MOD;
  localparam logic [W-1:0] LAST     = W'((1 << W) - 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [W-1:0]     cnt;
  logic [W-1:0]     lfsr;
  logic [W-1:0]     lfsr_rev;
  logic             fb;
  logic [COL-1:0]   mask_q;
  logic [W-1:0]     pmag    [COL];
  logic [W-1:0]     nmag    [COL];
  logic [W-1:0]     pmag_in [COL];
  logic [W-1:0]     nmag_in [COL];
  logic [BITWIDTH-1:0] lane_v;
  logic [BITWIDTH-1:0] lane_neg;

  // Maximal-length feedback taps for the lane magnitude width in use
  if (W == 4) begin : g_fb4
    always_comb fb = lfsr[3] ^ lfsr[2];
  end else if (W == 5) begin : g_fb5
    always_comb fb = lfsr[4] ^ lfsr[2];
  end else if (W == 6) begin : g_fb6
    always_comb fb = lfsr[5] ^ lfsr[4];
  end else if (W == 7) begin : g_fb7
    always_comb fb = lfsr[6] ^ lfsr[5];
  end else begin : g_fb8
    always_comb fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  end

  // Bit-reversed LFSR view used for the second stream bit
  always_comb begin
    lfsr_rev = '0;
    for (int unsigned i = 0; i < W; i++) lfsr_rev[i] = lfsr[W-1-i];
  end

  // Split each signed lane into magnitudes. -2^W wraps to 2^W on negation,
  // which only sets bit W, so that bit flags the saturation case.
  always_comb begin
    lane_v   = '0;
    lane_neg = '0;
    for (int unsigned k = 0; k < COL; k++) begin
      lane_v     = bin_in[BITWIDTH*k +: BITWIDTH];
      lane_neg   = '0 - lane_v;
      pmag_in[k] = '0;
      nmag_in[k] = '0;
      if (lane_v[BITWIDTH-1])
        nmag_in[k] = lane_neg[W] ? '1 : lane_neg[W-1:0];
      else
        pmag_in[k] = lane_v[W-1:0];
    end
  end

  // Control FSM, capture registers, cycle counter and LFSR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      lfsr   <= SEED_EFF;
      mask_q <= '0;
      for (int unsigned k = 0; k < COL; k++) begin
        pmag[k] <= '0;
        nmag[k] <= '0;
      end
    end else if (clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          for (int unsigned k = 0; k < COL; k++) begin
            pmag[k] <= pmag_in[k];
            nmag[k] <= nmag_in[k];
          end
          mask_q <= lane_mask;
          lfsr   <= SEED_EFF;
          cnt    <= '0;
          state  <= RUN;
        end
        RUN: begin
          lfsr <= {lfsr[W-2:0], fb};
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and status decode from the state register
  always_comb begin
    in_ready = (state == IDLE);
    cnt_en   = (state == RUN);
    done     = (state == DONE);
  end

  // Stream generation: comparators against registered state only
  always_comb begin
    sc_pos = '0;
    sc_neg = '0;
    if (state == RUN) begin
      for (int unsigned k = 0; k < COL; k++) begin
        if (mask_q[k]) begin
          sc_pos[2*k]   = (lfsr     <= pmag[k]);
          sc_pos[2*k+1] = (lfsr_rev <= pmag[k]);
          sc_neg[2*k]   = (lfsr     <= nmag[k]);
          sc_neg[2*k+1] = (lfsr_rev <= nmag[k]);
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2sc_array.sv
// Directed bench for bin2sc_array at BITWIDTH=8, COL=32, SEED=1 (W=7).
module tb_bin2sc_array;

  localparam int COL    = 32;
  localparam int RUNLEN = 127;

  logic          clk = 1'b0;
  logic          reset, clr, in_valid;
  logic [255:0]  bin_in;
  logic [31:0]   lane_mask;
  logic          in_ready, cnt_en, done;
  logic [63:0]   sc_pos, sc_neg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          mp [COL];
  int          mn [COL];
  logic [31:0] mmask;
  int          tot_pos [COL];
  int          tot_neg [COL];
  logic [63:0] pos_c1, pos_c2;
  int          run_cnt;

  bin2sc_array #(.BITWIDTH(8), .COL(32), .SEED(1)) dut (
    .clk(clk), .reset(reset), .clr(clr), .bin_in(bin_in),
    .in_valid(in_valid), .in_ready(in_ready), .lane_mask(lane_mask),
    .sc_pos(sc_pos), .sc_neg(sc_neg), .cnt_en(cnt_en), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] lfsr_next(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  function automatic logic [6:0] rev7(input logic [6:0] s);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = s[6-i];
    return r;
  endfunction

  task automatic set_model(input logic [255:0] b, input logic [31:0] m);
    logic signed [7:0] t;
    int v;
    mmask = m;
    for (int k = 0; k < COL; k++) begin
      t = b[8*k +: 8];
      v = t;
      if (v >= 0) begin
        mp[k] = v; mn[k] = 0;
      end else begin
        mp[k] = 0; mn[k] = (-v > 127) ? 127 : -v;
      end
    end
  endtask

  task automatic exp_streams(input logic [6:0] s, output logic [63:0] ep, output logic [63:0] en);
    int sv, rv;
    sv = int'(s);
    rv = int'(rev7(s));
    ep = '0;
    en = '0;
    for (int k = 0; k < COL; k++) begin
      if (mmask[k]) begin
        ep[2*k]   = (sv <= mp[k]);
        ep[2*k+1] = (rv <= mp[k]);
        en[2*k]   = (sv <= mn[k]);
        en[2*k+1] = (rv <= mn[k]);
      end
    end
  endtask

  task automatic load(input logic [255:0] b, input logic [31:0] m);
    @(negedge clk);
    chk("ready_before_load", in_ready, 1);
    bin_in    = b;
    lane_mask = m;
    in_valid  = 1'b1;
    set_model(b, m);
    @(negedge clk);
    in_valid  = 1'b0;
    bin_in    = ~b;
    lane_mask = ~m;
  endtask

  // mode 0: full run; 1: clr at cycle 'at'; 2: reset pulse at cycle 'at'
  task automatic do_run(input int mode, input int at);
    logic [6:0]  s;
    logic [63:0] ep, en;
    s = 7'h01;
    run_cnt = 0;
    for (int k = 0; k < COL; k++) begin
      tot_pos[k] = 0; tot_neg[k] = 0;
    end
    for (int c = 1; c <= RUNLEN; c++) begin
      exp_streams(s, ep, en);
      chk("run_cnt_en", cnt_en, 1);
      chk("run_sc_pos", sc_pos, ep);
      chk("run_sc_neg", sc_neg, en);
      if (cnt_en) run_cnt++;
      for (int k = 0; k < COL; k++) begin
        tot_pos[k] += int'(sc_pos[2*k]) + int'(sc_pos[2*k+1]);
        tot_neg[k] += int'(sc_neg[2*k]) + int'(sc_neg[2*k+1]);
      end
      if (c == 1) pos_c1 = sc_pos;
      if (c == 2) pos_c2 = sc_pos;
      if (mode == 1 && c == at) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_cnt_en", cnt_en, 0);
        chk("clr_sc_pos", sc_pos, 0);
        chk("clr_sc_neg", sc_neg, 0);
        chk("clr_ready", in_ready, 1);
        chk("clr_done", done, 0);
        @(negedge clk);
        chk("clr_done_late", done, 0);
        return;
      end
      if (mode == 2 && c == at) begin
        in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("arst_ready", in_ready, 1);
        chk("arst_cnt_en", cnt_en, 0);
        chk("arst_done", done, 0);
        chk("arst_sc_pos", sc_pos, 0);
        chk("arst_sc_neg", sc_neg, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("arst_after_ready", in_ready, 1);
        chk("arst_after_done", done, 0);
        return;
      end
      s = lfsr_next(s);
      @(negedge clk);
    end
    chk("run_length", 64'(run_cnt), 64'(RUNLEN));
    chk("done_pulse", done, 1);
    chk("done_cnt_en", cnt_en, 0);
    chk("done_sc_pos", sc_pos, 0);
    chk("done_sc_neg", sc_neg, 0);
    chk("done_ready", in_ready, 0);
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("idle_ready", in_ready, 1);
  endtask

  logic [255:0] b, a2, b2;
  int t0;

  initial begin
    reset = 1'b1; clr = 1'b0; in_valid = 1'b0; bin_in = '0; lane_mask = '0;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_done", done, 0);
    chk("rst_sc_pos", sc_pos, 0);
    chk("rst_sc_neg", sc_neg, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // lane0 = +5
    b = '0; b[7:0] = 8'd5;
    load(b, '1);
    do_run(0, 0);
    chk("l0_pos_total", 64'(tot_pos[0]), 64'd10);
    chk("l0_neg_total", 64'(tot_neg[0]), 64'd0);

    // lane1 = +127, lane2 = -128 (saturates)
    b = '0; b[15:8] = 8'd127; b[23:16] = 8'h80;
    load(b, '1);
    do_run(0, 0);
    chk("l1_pos_total", 64'(tot_pos[1]), 64'd254);
    chk("l2_neg_total", 64'(tot_neg[2]), 64'd254);
    chk("l2_pos_total", 64'(tot_pos[2]), 64'd0);

    // lane3 = -1, lane4 = +50 masked off
    b = '0; b[31:24] = 8'hFF; b[39:32] = 8'd50;
    load(b, ~32'h10);
    do_run(0, 0);
    chk("l3_neg_total", 64'(tot_neg[3]), 64'd2);
    chk("l4_pos_masked", 64'(tot_pos[4]), 64'd0);

    // LFSR start: lanes 0..3 = 0,1,2,3 decode S=1 then S=2
    b = '0; b[15:8] = 8'd1; b[23:16] = 8'd2; b[31:24] = 8'd3;
    load(b, '1);
    do_run(0, 0);
    chk("lfsr_cycle1", 64'(pos_c1[7:0]), 64'h54);
    chk("lfsr_cycle2", 64'(pos_c2[7:0]), 64'h50);
    chk("l3_thresh_total", 64'(tot_pos[3]), 64'd6);

    // clr on RUN cycle 40, then clr+in_valid in IDLE, then full run
    b = '0; b[7:0] = 8'd100;
    load(b, '1);
    do_run(1, 40);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; bin_in = b; lane_mask = '1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_blocks_load_cnt", cnt_en, 0);
    chk("clr_blocks_load_rdy", in_ready, 1);
    load(b, '1);
    do_run(0, 0);
    chk("post_clr_total", 64'(tot_pos[0]), 64'd200);

    // in_valid held high; data changed during RUN is ignored
    a2 = '0; a2[7:0] = 8'd20; a2[47:40] = 8'hF9;
    b2 = '0; b2[7:0] = 8'hFD; b2[55:48] = 8'd9;
    @(negedge clk);
    bin_in = a2; lane_mask = '1; in_valid = 1'b1;
    set_model(a2, '1);
    @(negedge clk);
    t0 = cyc;
    bin_in = b2;
    do_run(0, 0);
    chk("held_l0_total", 64'(tot_pos[0]), 64'd40);
    chk("held_l5_total", 64'(tot_neg[5]), 64'd14);
    set_model(b2, '1);
    @(negedge clk);
    chk("accept_spacing", 64'(cyc - t0), 64'd129);
    bin_in = a2;
    do_run(2, 60);

    // after reset, behaves like power-up
    b = '0; b[7:0] = 8'd5;
    load(b, '1);
    do_run(0, 0);
    chk("post_rst_total", 64'(tot_pos[0]), 64'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
